// File: rtl/csi2_raw_unpack.sv
// csi2_raw_unpack: CSI-2 RAW8/10/12 payload beats to one right-justified pixel per clock with line/frame framing
module csi2_raw_unpack #(
  parameter int LANES = 4,
  parameter int BUF_BYTES = 16,
  parameter int PIX_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*8-1:0] in_data,
  input  logic               in_last,
  input  logic [2:0]         in_bytes,
  input  logic               in_fs,
  input  logic               in_fe,
  output logic               out_valid,
  output logic [PIX_W-1:0]   out_pix,
  output logic               out_sol,
  output logic               out_eol,
  output logic               out_lv,
  output logic               out_fv,
  output logic [15:0]        line_pix,
  output logic               err_partial,
  output logic               err_mode
);
  localparam int CW = $clog2(BUF_BYTES + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state, state_nx;
  logic [7:0] fifo [BUF_BYTES];
  logic [7:0] fifo_nx [BUF_BYTES];
  logic [CW-1:0] cnt, cnt_nx, push_n, pop_n, grp;
  logic [1:0] mode_q, mode_eff, k, k_last;
  logic acc, emit, last_pix, fe_pend, fv_clr, drain_done;
  logic [15:0] pix_cnt;
  logic [11:0] pix;
  assign in_ready = !rst && state != DRAIN && cnt <= CW'(BUF_BYTES - LANES);
  assign acc = in_valid && in_ready;
  assign mode_eff = state == IDLE ? mode : mode_q;
  assign grp = mode_q == 2'd1 ? CW'(5) : mode_q == 2'd2 ? CW'(3) : CW'(1);
  assign k_last = mode_q == 2'd1 ? 2'd3 : mode_q == 2'd2 ? 2'd1 : 2'd0;
  assign emit = state != IDLE && mode_q != 2'd3 && cnt >= grp;
  assign pop_n = emit && k == k_last ? grp : '0;
  assign push_n = acc && mode_eff != 2'd3 ? (in_last ? CW'(in_bytes) : CW'(LANES)) : '0;
  assign cnt_nx = cnt - pop_n + push_n;
  assign drain_done = state == DRAIN && cnt < grp;
  assign last_pix = emit && k == k_last && (state == DRAIN || (acc && in_last)) && cnt_nx < grp;
  assign fv_clr = (in_fe && state == IDLE) || ((in_fe || fe_pend) && state_nx == IDLE);
  assign pix = mode_q == 2'd1 ? {2'd0, fifo[k], 2'(fifo[4] >> {k, 1'b0})}
             : mode_q == 2'd2 ? {fifo[k[0]], k[0] ? fifo[2][7:4] : fifo[2][3:0]}
             : {4'd0, fifo[0]};
  // line state: first accepted beat opens the line, last beat starts the drain, a sub-group remainder ends it
  always_comb begin
    state_nx = state == IDLE ? (acc ? (in_last ? DRAIN : ACTIVE) : IDLE)
             : state == ACTIVE ? (acc && in_last ? DRAIN : ACTIVE)
             : (cnt < grp ? IDLE : DRAIN);
  end
  // byte buffer shift: drop the popped group and append accepted bytes behind the survivors
  always_comb begin
    for (int i = 0; i < BUF_BYTES; i++) begin
      fifo_nx[i] = 8'd0;
      for (int j = 0; j < BUF_BYTES; j++) if (j == i + int'(pop_n) && j < int'(cnt)) fifo_nx[i] = fifo[j];
      for (int j = 0; j < LANES; j++) if (int'(cnt) + j == i + int'(pop_n)) fifo_nx[i] = in_data[j*8 +: 8];
    end
  end
  // line state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // buffer, unpack counters, registered pixel outputs, framing and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      mode_q <= '0;
      k <= '0;
      pix_cnt <= '0;
      fe_pend <= 1'b0;
      out_valid <= 1'b0;
      out_pix <= '0;
      out_sol <= 1'b0;
      out_eol <= 1'b0;
      out_lv <= 1'b0;
      out_fv <= 1'b0;
      line_pix <= '0;
      err_partial <= 1'b0;
      err_mode <= 1'b0;
    end else begin
      fifo <= fifo_nx;
      cnt <= drain_done ? '0 : cnt_nx;
      if (state == IDLE && acc) mode_q <= mode;
      k <= state == IDLE ? '0 : emit ? (k == k_last ? '0 : k + 2'd1) : k;
      pix_cnt <= state == IDLE ? '0 : emit && pix_cnt != 16'hFFFF ? pix_cnt + 16'd1 : pix_cnt;
      out_valid <= emit;
      out_pix <= emit ? PIX_W'(pix) : '0;
      out_sol <= emit && pix_cnt == 16'd0;
      out_eol <= last_pix;
      out_lv <= emit ? 1'b1 : out_eol ? 1'b0 : out_lv;
      if (last_pix) line_pix <= pix_cnt == 16'hFFFF ? pix_cnt : pix_cnt + 16'd1;
      err_partial <= drain_done && cnt != '0;
      err_mode <= acc && in_last && mode_eff == 2'd3;
      out_fv <= fv_clr ? 1'b0 : in_fs && !in_fe ? 1'b1 : out_fv;
      fe_pend <= !fv_clr && (in_fe || fe_pend);
    end
  end
endmodule

// File: tb/tb_csi2_raw_unpack.sv
// tb_csi2_raw_unpack: randomized and directed scoreboard bench for the CSI-2 raw unpacker
module tb_csi2_raw_unpack;
  localparam int LANES = 4;
  typedef struct packed {
    logic [11:0] pix;
    logic        sol;
    logic        eol;
    logic [15:0] lp;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [1:0] mode = 0;
  logic in_valid = 0, in_last = 0, in_fs = 0, in_fe = 0;
  logic [LANES*8-1:0] in_data = 0;
  logic [2:0] in_bytes = 0;
  logic in_ready, out_valid, out_sol, out_eol, out_lv, out_fv, err_partial, err_mode;
  logic [11:0] out_pix;
  logic [15:0] line_pix;
  logic [34:0] outs;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] lb[$];
  int checks = 0, errors = 0;
  int exp_part = 0, exp_mode = 0, n_part = 0, n_mode = 0, gaps = 0, stalls = 0;
  bit in_line = 0, fv_watch = 0, fv_next = 0, lv_next = 0, prev_part = 0, prev_mode = 0;

  csi2_raw_unpack #(.LANES(LANES), .BUF_BYTES(16), .PIX_W(12)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .in_fs(in_fs), .in_fe(in_fe),
    .out_valid(out_valid), .out_pix(out_pix), .out_sol(out_sol), .out_eol(out_eol),
    .out_lv(out_lv), .out_fv(out_fv), .line_pix(line_pix),
    .err_partial(err_partial), .err_mode(err_mode)
  );

  assign outs = {out_valid, out_pix, out_sol, out_eol, out_lv, out_fv, line_pix, err_partial, err_mode};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: whole groups yield pixels by plain arithmetic, a remainder flags a partial drop
  task automatic model(input logic [1:0] m);
    int g, p, ng, b, v;
    exp_t e;
    if (m == 2'd3) begin
      exp_mode++;
      return;
    end
    g = m == 2'd1 ? 5 : m == 2'd2 ? 3 : 1;
    p = m == 2'd1 ? 4 : m == 2'd2 ? 2 : 1;
    ng = lb.size() / g;
    if (lb.size() % g != 0) exp_part++;
    for (int i = 0; i < ng; i++)
      for (int kk = 0; kk < p; kk++) begin
        b = i * g;
        v = m == 2'd0 ? int'(lb[b])
          : m == 2'd1 ? int'(lb[b+kk]) * 4 + (int'(lb[b+4]) >> (2*kk)) % 4
          : int'(lb[b+kk]) * 16 + (int'(lb[b+2]) >> (4*kk)) % 16;
        e.pix = 12'(v);
        e.sol = (i == 0 && kk == 0);
        e.eol = (i == ng - 1 && kk == p - 1);
        e.lp = 16'(ng * p);
        exp_q.push_back(e);
      end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int nb);
    bit ok = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    in_bytes = 3'(nb);
    for (int t = 0; t < 500 && !ok; t++) begin
      #1 ok = in_ready;
      if (!ok) stalls++;
      @(negedge clk);
    end
    chk("beat_accept", ok, 1);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic send_line(input logic [1:0] m, input bit gapped);
    int len, nb;
    logic [31:0] d;
    len = lb.size();
    model(m);
    mode = m;
    for (int i = 0; i < len; i += LANES) begin
      nb = (len - i < LANES) ? len - i : LANES;
      d = '0;
      for (int j = 0; j < nb; j++) d[j*8 +: 8] = lb[i+j];
      send(d, i + LANES >= len, nb);
      if (gapped) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic rand_bytes(input int n);
    lb = {};
    repeat (n) lb.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_done", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_fs();
    in_fs = 1;
    @(negedge clk);
    in_fs = 0;
    chk("fv_rise", out_fv, 1);
  endtask

  // monitor: pops the scoreboard whenever a pixel is presented and checks framing around it
  always @(negedge clk) begin
    if (lv_next) begin
      chk("lv_fall", out_lv, 0);
      lv_next = 0;
    end
    if (fv_next) begin
      chk("fv_fall", out_fv, 0);
      fv_next = 0;
    end
    if (in_line && !out_valid) gaps++;
    if (out_valid) begin
      chk("lv_high", out_lv, 1);
      if (exp_q.size() == 0) chk("spurious_pixel", out_valid, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("pix", out_pix, mon_e.pix);
        chk("sol", out_sol, mon_e.sol);
        chk("eol", out_eol, mon_e.eol);
        if (mon_e.eol) begin
          chk("line_pix", line_pix, mon_e.lp);
          lv_next = 1;
          if (fv_watch) begin
            chk("fv_at_eol", out_fv, 1);
            fv_watch = 0;
            fv_next = 1;
          end
        end
      end
      in_line = !out_eol && (out_sol || in_line);
    end
    if (err_partial) begin
      n_part++;
      chk("err_partial_width", prev_part, 0);
    end
    if (err_mode) begin
      n_mode++;
      chk("err_mode_width", prev_mode, 0);
    end
    prev_part = err_partial;
    prev_mode = err_mode;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 chk("ready_in_rst", in_ready, 0);
    chk("outs_in_rst", outs, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("ready_after_rst", in_ready, 1);
    chk("outs_after_rst", outs, 0);
    @(negedge clk);
    pulse_fs();
    gaps = 0;
    lb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hE4};
    send_line(2'd1, 0);
    wait_done();
    chk("raw10_gapless", gaps, 0);
    lb = '{8'hAB, 8'hCD, 8'h21};
    send_line(2'd2, 0);
    wait_done();
    lb = '{8'h10, 8'h11, 8'h12, 8'h13};
    send_line(2'd0, 0);
    wait_done();
    chk("no_err_yet", n_part + n_mode, 0);
    rand_bytes(7);
    send_line(2'd1, 0);
    wait_done();
    chk("err_partial_7b", n_part, exp_part);
    rand_bytes(5);
    send_line(2'd1, 0);
    wait_done();
    gaps = 0;
    stalls = 0;
    rand_bytes(40);
    fv_watch = 1;
    send_line(2'd1, 0);
    in_fe = 1;
    @(negedge clk);
    in_fe = 0;
    wait_done();
    chk("raw10_40b_gapless", gaps, 0);
    chk("ready_toggled", stalls > 0, 1);
    chk("fe_eol_seen", fv_watch, 0);
    chk("fv_low_after_line", out_fv, 0);
    in_fs = 1;
    in_fe = 1;
    @(negedge clk);
    in_fs = 0;
    in_fe = 0;
    chk("fv_fs_fe", out_fv, 0);
    pulse_fs();
    mode = 2'd1;
    send(32'h44332211, 0, 4);
    rst = 1;
    #1 chk("ready_in_midline_rst", in_ready, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("outs_after_midline_rst", outs, 0);
    chk("ready_after_midline_rst", in_ready, 1);
    @(negedge clk);
    pulse_fs();
    lb = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h7E};
    send_line(2'd0, 0);
    wait_done();
    rand_bytes(9);
    send_line(2'd3, 0);
    wait_done();
    chk("err_mode_pulse", n_mode, exp_mode);
    for (int n = 0; n < 30; n++) begin
      rand_bytes($urandom_range(1, 40));
      send_line($urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2)), 1);
    end
    wait_done();
    chk("err_partial_total", n_part, exp_part);
    chk("err_mode_total", n_mode, exp_mode);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
